seq_step_sched: RTL and testbench

Programmable scheduler that sequences a 3-bit number generator from a small pattern table.
- Each table entry holds a 3-bit number and a dwell count.
- Presents each entry to a downstream consumer through a valid/ack handshake, holds it for its dwell, then advances.
- Supports run, pause, single-step, stop and loop/one-shot modes.
- Sits between the control/config logic and the number-display/consumer path.

---
 rtl/seq_step_sched.sv | 169 ++++++++++++++++
 tb/tb_seq_step_sched.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_step_sched.sv
// Pattern-table scheduler: presents {number} entries over a valid/ack handshake,
// dwells per entry, and supports run / pause / single-step / stop / loop modes.
module seq_step_sched #(
    parameter int DWELL_W = 4,
    parameter int DEPTH   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic               step,
    input  logic               loop,
    input  logic [2:0]         last_idx,
    input  logic               wr_en,
    input  logic [2:0]         wr_addr,
    input  logic [2:0]         wr_num,
    input  logic [DWELL_W-1:0] wr_dwell,
    output logic [2:0]         number,
    output logic               num_vld,
    input  logic               num_ack,
    output logic [2:0]         cur_idx,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_DWELL, S_PAUSED} state_t;

    state_t             state_reg, state_next;
    logic [2:0]         tbl_num_reg   [DEPTH];
    logic [DWELL_W-1:0] tbl_dwell_reg [DEPTH];

    logic [2:0]         number_reg, number_next;
    logic               num_vld_reg, num_vld_next;
    logic [2:0]         cur_idx_reg, cur_idx_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic [DWELL_W-1:0] cnt_reg, cnt_next;
    logic [DWELL_W-1:0] hold_reg, hold_next;
    logic               step_flag_reg, step_flag_next;

    // A cur_idx beyond last_idx (last_idx lowered mid-run) counts as the end.
    logic       at_last, seq_end;
    logic [2:0] adv_idx;
    assign at_last = (cur_idx_reg >= last_idx);
    assign seq_end = at_last && !loop;
    assign adv_idx = at_last ? 3'd0 : cur_idx_reg + 3'd1;

    logic do_stop, do_first, do_ack, do_dec, do_adv;
    assign do_stop  = (state_reg != S_IDLE) && stop;
    assign do_first = (state_reg == S_IDLE) && start;
    assign do_ack   = (state_reg == S_PRESENT) && !stop && num_ack;
    assign do_dec   = (state_reg == S_DWELL) && !stop && !pause && (cnt_reg != '0);
    assign do_adv   = ((state_reg == S_DWELL) && !stop && !pause && (cnt_reg == '0))
                   || ((state_reg == S_PAUSED) && !stop && !start && !pause && step);

    // Table storage: cleared on reset, writable in any state.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!rst) begin
                tbl_num_reg[i]   <= '0;
                tbl_dwell_reg[i] <= '0;
            end else if (wr_en && (wr_addr == i[2:0])) begin
                tbl_num_reg[i]   <= wr_num;
                tbl_dwell_reg[i] <= wr_dwell;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= S_IDLE;
            number_reg    <= '0;
            num_vld_reg   <= 1'b0;
            cur_idx_reg   <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            cnt_reg       <= '0;
            hold_reg      <= '0;
            step_flag_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            number_reg    <= number_next;
            num_vld_reg   <= num_vld_next;
            cur_idx_reg   <= cur_idx_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            cnt_reg       <= cnt_next;
            hold_reg      <= hold_next;
            step_flag_reg <= step_flag_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_IDLE: begin
                if (start) state_next = S_PRESENT;
            end
            S_PRESENT: begin
                if (stop)         state_next = S_IDLE;
                else if (num_ack) state_next = step_flag_reg ? S_PAUSED : S_DWELL;
            end
            S_DWELL: begin
                if (stop)                state_next = S_IDLE;
                else if (pause)          state_next = S_PAUSED;
                else if (cnt_reg == '0)  state_next = seq_end ? S_IDLE : S_PRESENT;
            end
            S_PAUSED: begin
                if (stop)        state_next = S_IDLE;
                else if (start)  state_next = S_DWELL;
                else if (pause)  state_next = S_PAUSED;
                else if (step)   state_next = seq_end ? S_IDLE : S_PRESENT;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Dwell is captured at load so a rewrite of the playing entry only affects its next load.
    always_comb begin
        number_next    = number_reg;
        num_vld_next   = num_vld_reg;
        cur_idx_next   = cur_idx_reg;
        cnt_next       = cnt_reg;
        hold_next      = hold_reg;
        step_flag_next = step_flag_reg;
        done_next      = 1'b0;
        busy_next      = (state_next != S_IDLE);
        if (do_stop) begin
            number_next    = '0;
            num_vld_next   = 1'b0;
            cur_idx_next   = '0;
            step_flag_next = 1'b0;
        end else if (do_first) begin
            cur_idx_next   = '0;
            number_next    = tbl_num_reg[0];
            hold_next      = tbl_dwell_reg[0];
            num_vld_next   = 1'b1;
            step_flag_next = 1'b0;
        end else if (do_ack) begin
            num_vld_next   = 1'b0;
            cnt_next       = hold_reg;
            step_flag_next = 1'b0;
        end else if (do_dec) begin
            cnt_next = cnt_reg - DWELL_W'(1);
        end else if (do_adv) begin
            if (seq_end) begin
                number_next    = '0;
                cur_idx_next   = '0;
                num_vld_next   = 1'b0;
                step_flag_next = 1'b0;
                done_next      = 1'b1;
            end else begin
                cur_idx_next   = adv_idx;
                number_next    = tbl_num_reg[adv_idx];
                hold_next      = tbl_dwell_reg[adv_idx];
                num_vld_next   = 1'b1;
                step_flag_next = (state_reg == S_PAUSED);
            end
        end
    end

    assign number  = number_reg;
    assign num_vld = num_vld_reg;
    assign cur_idx = cur_idx_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;

endmodule

// File: tb/tb_seq_step_sched.sv
// Bench for seq_step_sched: directed vector table, hand-written corner sequences,
// and randomized traffic compared every cycle against a behavioural model.
module tb_seq_step_sched;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0, stop = 1'b0, pause = 1'b0, step = 1'b0, loop = 1'b0;
    logic [2:0]    last_idx = 3'd0;
    logic          wr_en = 1'b0;
    logic [2:0]    wr_addr = 3'd0, wr_num = 3'd0;
    logic [DW-1:0] wr_dwell = '0;
    logic          num_ack = 1'b0;
    logic [2:0]    number, cur_idx;
    logic          num_vld, busy, done;

    seq_step_sched #(.DWELL_W(DW), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause), .step(step),
        .loop(loop), .last_idx(last_idx), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_num(wr_num), .wr_dwell(wr_dwell), .number(number), .num_vld(num_vld),
        .num_ack(num_ack), .cur_idx(cur_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: m_left = DWELL cycles still to spend on the current entry.
    typedef enum int {M_IDLE, M_PRESENT, M_DWELL, M_PAUSED} mphase_t;
    mphase_t m_phase = M_IDLE;
    int m_left = 0, m_idx = 0, m_num = 0, m_hold = 0;
    bit m_vld = 0, m_done = 0, m_flag = 0;
    int m_tbl_num [8];
    int m_tbl_dw  [8];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic m_go_idle();
        m_phase = M_IDLE; m_num = 0; m_idx = 0; m_vld = 0; m_flag = 0;
    endtask

    task automatic m_load(input int i, input bit flag);
        m_phase = M_PRESENT; m_idx = i; m_num = m_tbl_num[i]; m_hold = m_tbl_dw[i];
        m_vld = 1; m_flag = flag;
    endtask

    task automatic m_advance(input bit from_step);
        if (m_idx >= int'(last_idx) && !loop) begin
            m_go_idle();
            m_done = 1;
        end else begin
            m_load((m_idx >= int'(last_idx)) ? 0 : m_idx + 1, from_step);
        end
    endtask

    task automatic model_update();
        m_done = 0;
        if (!rst) begin
            m_go_idle();
            m_left = 0; m_hold = 0;
            for (int i = 0; i < 8; i++) begin
                m_tbl_num[i] = 0; m_tbl_dw[i] = 0;
            end
            return;
        end
        case (m_phase)
            M_IDLE:    if (start) m_load(0, 0);
            M_PRESENT: begin
                if (stop) m_go_idle();
                else if (num_ack) begin
                    m_vld = 0;
                    m_left = m_hold + 1;
                    m_phase = m_flag ? M_PAUSED : M_DWELL;
                    m_flag = 0;
                end
            end
            M_DWELL: begin
                if (stop) m_go_idle();
                else if (pause) m_phase = M_PAUSED;
                else begin
                    m_left--;
                    if (m_left == 0) m_advance(0);
                end
            end
            M_PAUSED: begin
                if (stop) m_go_idle();
                else if (start) m_phase = M_DWELL;
                else if (!pause && step) m_advance(1);
            end
            default: m_go_idle();
        endcase
        if (wr_en) begin
            m_tbl_num[wr_addr] = int'(wr_num);
            m_tbl_dw[wr_addr]  = int'(wr_dwell);
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
        check("number", int'(number), m_num);
        check("num_vld", int'(num_vld), int'(m_vld));
        check("cur_idx", int'(cur_idx), m_idx);
        check("busy", int'(busy), int'(m_phase != M_IDLE));
        check("done", int'(done), int'(m_done));
    endtask

    task automatic clr_cmds();
        start = 0; stop = 0; pause = 0; step = 0; num_ack = 0; wr_en = 0;
    endtask

    task automatic wr(input int a, input int n, input int d);
        wr_en = 1; wr_addr = 3'(a); wr_num = 3'(n); wr_dwell = DW'(d);
        tick();
        wr_en = 0;
    endtask

    task automatic run_until_idle(input int bound);
        int n = 0;
        while (m_phase != M_IDLE && n < bound) begin
            num_ack = m_vld;
            tick();
            n++;
        end
        num_ack = 0;
        check("idle_reached", int'(busy), 0);
    endtask

    typedef struct {
        bit start, stop, pause, step, ack;
        int num; bit vld; int idx; bit busy, done;
    } vec_t;
    vec_t vecs[12];

    initial begin
        int k, age, pres, c;
        bit found;

        vecs[0]  = '{1,0,0,0,0, 5,1,0,1,0};
        vecs[1]  = '{0,0,0,0,0, 5,1,0,1,0};
        vecs[2]  = '{0,0,0,0,1, 5,0,0,1,0};
        vecs[3]  = '{0,0,0,0,0, 5,0,0,1,0};
        vecs[4]  = '{0,0,0,0,0, 5,0,0,1,0};
        vecs[5]  = '{0,0,0,0,0, 3,1,1,1,0};
        vecs[6]  = '{0,0,0,0,0, 3,1,1,1,0};
        vecs[7]  = '{0,0,0,0,1, 3,0,1,1,0};
        vecs[8]  = '{0,0,0,0,0, 0,0,0,0,1};
        vecs[9]  = '{0,0,0,0,0, 0,0,0,0,0};
        vecs[10] = '{0,0,1,1,1, 0,0,0,0,0};
        vecs[11] = '{0,1,0,0,0, 0,0,0,0,0};

        // Reset state
        rst = 0;
        repeat (3) tick();
        check("rst_number", int'(number), 0);
        check("rst_vld", int'(num_vld), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1;

        // Test 1: one-shot two-entry sequence from the vector table
        wr(0, 5, 2);
        wr(1, 3, 0);
        last_idx = 3'd1; loop = 0;
        for (int i = 0; i < 12; i++) begin
            start = vecs[i].start; stop = vecs[i].stop; pause = vecs[i].pause;
            step = vecs[i].step; num_ack = vecs[i].ack;
            tick();
            check($sformatf("vec%0d_number", i), int'(number), vecs[i].num);
            check($sformatf("vec%0d_vld", i), int'(num_vld), int'(vecs[i].vld));
            check($sformatf("vec%0d_idx", i), int'(cur_idx), vecs[i].idx);
            check($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].busy));
            check($sformatf("vec%0d_done", i), int'(done), int'(vecs[i].done));
        end
        clr_cmds();

        // Test 2: looping with ack delayed 4 cycles; entries alternate 5@0 / 3@1
        loop = 1;
        start = 1; tick(); start = 0;
        age = 0; pres = 0;
        for (int i = 0; i < 80; i++) begin
            age = m_vld ? age + 1 : 0;
            num_ack = (age == 4);
            if (num_ack) begin
                check("loop_idx", int'(cur_idx), pres % 2);
                check("loop_num", int'(number), (pres % 2) ? 3 : 5);
                pres++;
            end
            tick();
        end
        check("loop_enough_presents", int'(pres >= 6), 1);
        num_ack = 0; stop = 1; tick(); stop = 0;

        // Test 3: pause mid-dwell then resume; dwell 6 spends 7 unpaused cycles
        wr(0, 5, 6);
        loop = 0;
        start = 1; tick(); start = 0;
        tick();
        num_ack = 1; tick(); num_ack = 0;
        k = 0;
        tick(); k++;
        pause = 1; repeat (5) begin tick(); k++; end
        pause = 0; start = 1; tick(); k++; start = 0;
        while (!num_vld && k < 40) begin tick(); k++; end
        check("pause_resume_len", k, 13);
        run_until_idle(60);

        // Test 4: single-step while paused
        start = 1; tick(); start = 0;
        num_ack = 1; tick(); num_ack = 0;
        pause = 1; tick(); pause = 0;
        step = 1; tick(); step = 0;
        check("step_num", int'(number), 3);
        check("step_vld", int'(num_vld), 1);
        num_ack = 1; tick(); num_ack = 0;
        repeat (4) tick();
        check("step_paused_busy", int'(busy), 1);
        check("step_paused_vld", int'(num_vld), 0);
        step = 1; tick(); step = 0;
        check("step_end_done", int'(done), 1);
        tick();
        check("step_end_busy", int'(busy), 0);

        // Test 5: stop in PRESENT with ack, stop in DWELL, reset mid-DWELL
        start = 1; tick(); start = 0;
        stop = 1; num_ack = 1; tick(); stop = 0; num_ack = 0;
        check("stop_present_vld", int'(num_vld), 0);
        check("stop_present_done", int'(done), 0);
        start = 1; tick(); start = 0;
        num_ack = 1; tick(); num_ack = 0;
        tick();
        stop = 1; tick(); stop = 0;
        check("stop_dwell_busy", int'(busy), 0);
        check("stop_dwell_done", int'(done), 0);
        start = 1; tick(); start = 0;
        num_ack = 1; tick(); num_ack = 0;
        tick();
        rst = 0; tick(); rst = 1;
        check("rst_mid_busy", int'(busy), 0);
        start = 1; tick(); start = 0;
        check("cleared_num", int'(number), 0);
        check("cleared_vld", int'(num_vld), 1);
        run_until_idle(40);

        // Test 6: write entry 1 on the edge that loads it
        wr(0, 5, 2);
        wr(1, 3, 0);
        loop = 1; last_idx = 3'd1;
        start = 1; tick(); start = 0;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            if (m_phase == M_DWELL && m_left == 1 && m_idx == 0) begin
                found = 1;
                break;
            end
            num_ack = m_vld;
            tick();
        end
        check("wr_adv_found", int'(found), 1);
        num_ack = 0;
        wr_en = 1; wr_addr = 3'd1; wr_num = 3'd6; wr_dwell = '0;
        tick();
        wr_en = 0;
        check("wr_same_cycle_old", int'(number), 3);
        check("wr_same_cycle_idx", int'(cur_idx), 1);
        found = 0;
        for (int i = 0; i < 40; i++) begin
            num_ack = m_vld;
            tick();
            if (m_vld && m_idx == 1) begin
                found = 1;
                break;
            end
        end
        num_ack = 0;
        check("wr_next_pass_found", int'(found), 1);
        check("wr_next_pass_new", int'(number), 6);
        stop = 1; tick(); stop = 0;

        // Randomized traffic against the model
        for (int i = 0; i < 8; i++) wr(i, $urandom_range(7), $urandom_range(3));
        c = 0;
        repeat (2000) begin
            start   = ($urandom_range(99) < 10);
            stop    = ($urandom_range(99) < 3);
            pause   = ($urandom_range(99) < 15);
            step    = ($urandom_range(99) < 12);
            num_ack = ($urandom_range(99) < 50);
            wr_en   = ($urandom_range(99) < 10);
            wr_addr = 3'($urandom_range(7));
            wr_num  = 3'($urandom_range(7));
            wr_dwell = DW'($urandom_range(3));
            if ($urandom_range(99) < 5) last_idx = 3'($urandom_range(7));
            if ($urandom_range(99) < 5) loop = ~loop;
            rst = ($urandom_range(999) < 5) ? 1'b0 : 1'b1;
            tick();
            c++;
        end
        rst = 1;
        clr_cmds();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
